// File: rtl/vga_pkg.sv
// Shared constants for the VGA display path: cell geometry, bus widths,
// sequencer state encoding and row-operation select codes.
package vga_pkg;

  localparam int unsigned COLS   = 40;
  localparam int unsigned ROWS   = 30;
  localparam int unsigned CELLS  = COLS * ROWS;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned ROW_W  = COLS;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned ST_W   = 2;
  localparam int unsigned OP_W   = 2;

  // Sequencer state encoding
  typedef logic [ST_W-1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_CLEAR  = 2'd1;
  localparam state_t ST_SCROLL = 2'd2;

  // Per-cycle row operation applied to the storage row at row_idx
  typedef logic [OP_W-1:0] row_op_t;
  localparam row_op_t OP_NONE  = 2'd0;
  localparam row_op_t OP_FILL  = 2'd1;
  localparam row_op_t OP_SHIFT = 2'd2;

  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

  // Bit offset of the first cell of row r in the packed bitmap
  function automatic logic [ADDR_W-1:0] row_base(input logic [CNT_W-1:0] r);
    return ADDR_W'(r) * ADDR_W'(ROW_W);
  endfunction

endpackage

// File: rtl/vga_row_sequencer.sv
// Bulk-operation sequencer for the cell buffer: IDLE/CLEAR/SCROLL FSM, 5-bit
// row counter and fill-value latch.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   clr_req, scroll_req start requests, honoured only in IDLE (clear wins)
//   fill_val            fill value, latched when an op starts
//   row_idx             row being updated this cycle
//   row_op_c            operation for row_idx this cycle (combinational decode)
//   fill                latched fill value
//   busy                high while CLEAR or SCROLL is running
//   done                one-cycle pulse together with busy falling
module vga_row_sequencer
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_req,
  input  logic             scroll_req,
  input  logic             fill_val,
  output logic [CNT_W-1:0] row_idx,
  output logic [OP_W-1:0]  row_op_c,
  output logic             fill,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fill_q, fill_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, counter and row-operation decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fill_d   = fill_q;
    done_d   = 1'b0;
    row_op_c = OP_NONE;

    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          fill_d  = fill_val;
        end else if (scroll_req) begin
          state_d = ST_SCROLL;
          cnt_d   = '0;
          fill_d  = fill_val;
        end
      end
      ST_CLEAR: begin
        row_op_c = OP_FILL;
      end
      ST_SCROLL: begin
        // Last row has no successor; it takes the fill value instead
        row_op_c = (cnt_q == LAST_ROW) ? OP_FILL : OP_SHIFT;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Shared row stepping for both bulk operations
    if (state_q == ST_CLEAR || state_q == ST_SCROLL) begin
      if (cnt_q == LAST_ROW) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign row_idx = cnt_q;
  assign fill    = fill_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: rtl/vga_cell_buffer.sv
// 40x30 one-bit cell bitmap feeding the VGA pixel stage. Single-cell bus
// writes in IDLE; clear-screen and scroll-up run one row per clock through
// vga_row_sequencer.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   wr_en/wr_addr/wr_data  single-cell write (index = row*40 + col)
//   clr_req, scroll_req    bulk op requests (IDLE only, clear wins)
//   fill_val               fill value for clear / new bottom row on scroll
//   busy, done             bulk op in progress / completion pulse
//   wr_drop                pulse when a write was discarded
//   data_out               packed bitmap, row r at [40r+39:40r], MSB tied 0
module vga_cell_buffer
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data,
  input  logic              clr_req,
  input  logic              scroll_req,
  input  logic              fill_val,
  output logic              busy,
  output logic              done,
  output logic              wr_drop,
  output logic [CELLS:0]    data_out
);

  logic [CELLS-1:0]  bits_q, bits_d;
  logic              wr_drop_q, wr_drop_d;
  logic [CNT_W-1:0]  row_idx;
  logic [OP_W-1:0]   row_op_c;
  logic              fill;
  logic [ADDR_W-1:0] base_c;
  logic [ADDR_W-1:0] src_c;

  vga_row_sequencer u_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_req    (clr_req),
    .scroll_req (scroll_req),
    .fill_val   (fill_val),
    .row_idx    (row_idx),
    .row_op_c   (row_op_c),
    .fill       (fill),
    .busy       (busy),
    .done       (done)
  );

  // Storage and drop-pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_q    <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      bits_q    <= bits_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Write decode and row update
  always_comb begin
    bits_d    = bits_q;
    wr_drop_d = 1'b0;
    base_c    = row_base(row_idx);
    src_c     = base_c + ADDR_W'(ROW_W);

    if (!busy) begin
      if (wr_en) begin
        if (wr_addr < ADDR_W'(CELLS)) begin
          bits_d[wr_addr] = wr_data;
        end else begin
          wr_drop_d = 1'b1;
        end
      end
    end else begin
      wr_drop_d = wr_en;
    end

    case (row_op_c)
      OP_FILL:  bits_d[base_c +: ROW_W] = {ROW_W{fill}};
      OP_SHIFT: bits_d[base_c +: ROW_W] = bits_q[src_c +: ROW_W];
      default:  ;
    endcase
  end

  assign wr_drop  = wr_drop_q;
  assign data_out = {1'b0, bits_q};

endmodule
